fetch_queue_unit: RTL and testbench
===================================

Name: fetch_queue_unit

Overview:
- Parametrised next-generation instruction fetch stage: owns the PC, issues sequential reads to a 1-cycle-latency synchronous instruction memory, and buffers returned instructions with their PCs in a DEPTH-entry queue.
- Feeds decode through a valid/ready handshake. Decode stalls therefore never stall the PC directly.
- Supports branch redirect with queue flush and squashing of the in-flight memory response.

Parameters:
- ADDR_W, 64, PC / address width in bits.
- INSTR_W, 32, instruction width in bits.
- DEPTH, 4, queue entries; power of two, ≥2.
- RESET_PC, 0, PC value loaded on reset.
- PC_INC, 4, sequential PC increment in bytes.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high reset.
- redirect_valid  in  1  branch taken / redirect request this cycle.
- redirect_pc  in  ADDR_W  redirect target address.
- imem_rd_en  out  1  memory read strobe.
- imem_addr  out  ADDR_W  read address; equals the PC register.
- imem_rdata  in  INSTR_W  read data, valid the cycle after imem_rd_en.
- out_valid  out  1  queue head valid.
- out_ready  in  1  decode accepts the head.
- out_instr  out  INSTR_W  head instruction.
- out_pc  out  ADDR_W  PC of the head instruction.

Behaviour:
- Reset (asynchronous, active-high), all state cleared:
  - pc = RESET_PC, queue empty, inflight = 0.
  - out_valid = 0, out_instr = 0, out_pc = 0.
  - imem_rd_en is forced 0 while reset is high.
- Issue (combinational):
  - Condition: imem_rd_en = !reset && !redirect_valid && (count + inflight < DEPTH).
  - count is the registered queue occupancy.
  - On issue: pc <= pc + PC_INC (mod 2^ADDR_W, wraps silently); inflight <= 1; inflight_pc <= pc.
  - With no issue and no response that cycle: inflight <= 0.
- Response:
  - If inflight == 1 and no redirect this cycle, push {imem_rdata, inflight_pc} at the clock edge.
  - Latency: rd_en at cycle t → out_valid at cycle t+2 (queue output is registered, no bypass).
- Pop: on out_valid && out_ready at the edge, the head is removed.
- Simultaneous push and pop:
  - Allowed at any occupancy, including full; count unchanged.
  - Overflow is impossible by the credit rule.
  - out_valid = (count != 0).
- Redirect (redirect_valid = 1 at an edge):
  - pc <= redirect_pc; queue flushed (count <= 0, pointers <= 0); inflight <= 0.
  - The response arriving that cycle is discarded.
  - A pop in the same cycle is ignored; the flush dominates.
  - No issue occurs in the redirect cycle.
  - First fetch from the target is issued in the next cycle.
  - Back-to-back redirects: the last one wins.
- Sustained throughput: 1 instruction/cycle when out_ready is held high.
- Full / empty boundaries:
  - Queue full and out_ready low: issue stalls, PC holds.
  - Empty: out_instr/out_pc hold their last values and are don't-care when out_valid = 0.
- Reset mid-operation: immediate return to the reset state; the pending memory response is ignored because inflight is cleared.

Optional Feature:
- Macro FETCH_PERF_CNT_EN.
- Defined:
  - Adds 32-bit outputs fetch_cnt, stall_cnt and flush_cnt.
  - fetch_cnt: issued reads. stall_cnt: cycles with !reset, no redirect and no issue because credits are exhausted. flush_cnt: redirects.
  - All counters reset to 0, saturate at 2^32-1, and are not cleared by redirect.
- Undefined: these ports and registers do not exist; behaviour is otherwise identical.

Decomposition:
- Shared package fetch_pkg:
  - Width constants WORD=64 and INSTR_LEN=32.
  - Typedef fetch_entry_t {instr, pc}.
  - Constant PC_STEP=4.
- Sub-module fetch_fifo (DEPTH, entry width): synchronous FIFO with push/pop/flush, count, and registered head. The fetch unit keeps PC, inflight and credit logic.

Test Plan:
- Reset release, RESET_PC=0x1000, out_ready=1, memory returns addr>>2 → out_pc 0x1000, 0x1004, 0x1008 on consecutive cycles; first out_valid two cycles after first rd_en.
- out_ready=0 for 10 cycles, DEPTH=4 → exactly 4 reads issued, then imem_rd_en=0 with PC held at 0x1010; releasing out_ready drains 0x1000..0x100C in order.
- Redirect to 0x2000 while the queue holds 3 entries with a read in flight → next cycle out_valid=0, stale response not pushed; next out_pc is 0x2000.
- Redirect on two consecutive cycles (0x3000, then 0x4000) → no 0x3000 entry ever appears; first output is 0x4000.
- Full queue with simultaneous pop and push → count stays 4, FIFO order preserved, no entry lost or duplicated.
- PC=0xFFFF_FFFF_FFFF_FFFC fetched → next imem_addr 0x0; with FETCH_PERF_CNT_EN defined, fetch_cnt/stall_cnt/flush_cnt match counts scoreboarded over all prior scenarios.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared widths, default PC step and fetch queue entry layout for the fetch stage.
// Also holds a saturating counter increment.
package fetch_pkg;

  localparam int WORD      = 64;
  localparam int INSTR_LEN = 32;
  localparam int PC_STEP   = 4;

  typedef struct packed {
    logic [INSTR_LEN-1:0] instr;
    logic [WORD-1:0]      pc;
  } fetch_entry_t;

  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO with flush and a registered head entry; push-to-head latency 1 cycle.
// No internal backpressure: the producer must hold off pushes when count == DEPTH.
module fetch_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 96,
  localparam int CW   = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_vld,
  input  logic [WIDTH-1:0] push_dat,
  input  logic             pop,
  input  logic             flush,
  output logic [CW-1:0]    count,
  output logic             head_vld,
  output logic [WIDTH-1:0] head_dat
);

  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr_nxt;
  logic             do_push;
  logic             do_pop;

  assign head_vld   = (count != '0);
  assign rd_ptr_nxt = rd_ptr + PW'(1);
  assign do_push    = push_vld && !flush;
  assign do_pop     = pop && head_vld && !flush;

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_dat;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      head_dat <= '0;
    end else if (flush) begin
      // Head register deliberately keeps its last value across a flush.
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr_nxt;

      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase

      // The next head comes from storage unless the queue drains to the incoming entry.
      if (do_pop) begin
        if (count > CW'(1))  head_dat <= mem[rd_ptr_nxt];
        else if (do_push)    head_dat <= push_dat;
      end else if (do_push && count == '0) begin
        head_dat <= push_dat;
      end
    end
  end

endmodule

// File: rtl/fetch_queue_unit.sv
// Fetch stage: PC, 1-cycle imem reads, DEPTH-entry queue to decode; rd_en to out_valid is 2 cycles.
// Decode backpressure only throttles issue via queue credits; FETCH_PERF_CNT_EN adds perf counters.
module fetch_queue_unit
  import fetch_pkg::*;
#(
  parameter int                ADDR_W   = WORD,
  parameter int                INSTR_W  = INSTR_LEN,
  parameter int                DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int                PC_INC   = PC_STEP
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_pc,
  output logic               imem_rd_en,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [INSTR_W-1:0] out_instr,
  output logic [ADDR_W-1:0]  out_pc
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]        fetch_cnt,
  output logic [31:0]        stall_cnt,
  output logic [31:0]        flush_cnt
`endif
);

  localparam int CW = $clog2(DEPTH) + 1;

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [ADDR_W-1:0]  pc;
  } entry_t;

  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] inflight_pc;
  logic              inflight;
  logic [CW-1:0]     count;
  logic [CW-1:0]     credit_used;
  logic              issue;
  logic              push;
  logic              pop;
  logic              q_vld;
  entry_t            push_ent;
  entry_t            head_ent;

  // An outstanding read already owns a queue slot, so it counts against the credits.
  assign credit_used = count + CW'(inflight);
  assign issue       = !reset && !redirect_valid && (credit_used < CW'(DEPTH));
  assign push        = inflight && !redirect_valid;
  assign pop         = q_vld && out_ready;
  assign push_ent    = '{instr: imem_rdata, pc: inflight_pc};

  assign imem_rd_en  = issue;
  assign imem_addr   = pc;
  assign out_valid   = q_vld;
  assign out_instr   = head_ent.instr;
  assign out_pc      = head_ent.pc;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc          <= RESET_PC;
      inflight    <= 1'b0;
      inflight_pc <= '0;
    end else begin
      inflight <= issue;
      if (redirect_valid) begin
        pc <= redirect_pc;
      end else if (issue) begin
        pc          <= pc + ADDR_W'(PC_INC);
        inflight_pc <= pc;
      end
    end
  end

  fetch_fifo #(
    .DEPTH (DEPTH),
    .WIDTH ($bits(entry_t))
  ) u_fifo (
    .clk      (clk),
    .rst      (reset),
    .push_vld (push),
    .push_dat (push_ent),
    .pop      (pop),
    .flush    (redirect_valid),
    .count    (count),
    .head_vld (q_vld),
    .head_dat (head_ent)
  );

`ifdef FETCH_PERF_CNT_EN
  logic stall;

  assign stall = !reset && !redirect_valid && !issue;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_cnt <= '0;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (issue)          fetch_cnt <= sat_inc32(fetch_cnt);
      if (stall)          stall_cnt <= sat_inc32(stall_cnt);
      if (redirect_valid) flush_cnt <= sat_inc32(flush_cnt);
    end
  end
`endif

endmodule

// File: tb/tb_fetch_queue_unit.sv
// Scoreboard bench for fetch_queue_unit: expected program-order stream per reset/redirect target.
module tb_fetch_queue_unit;
  import fetch_pkg::*;

  localparam int          DEPTH  = 4;
  localparam logic [63:0] RST_PC = 64'h1000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        redirect_valid = 1'b0;
  logic [63:0] redirect_pc = '0;
  logic        imem_rd_en;
  logic [63:0] imem_addr;
  logic [31:0] imem_rdata = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_instr;
  logic [63:0] out_pc;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_cnt, stall_cnt, flush_cnt;
`endif

  fetch_queue_unit #(.ADDR_W(64), .INSTR_W(32), .DEPTH(DEPTH), .RESET_PC(RST_PC), .PC_INC(4)) dut (
    .clk            (clk),
    .reset          (reset),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_rd_en     (imem_rd_en),
    .imem_addr      (imem_addr),
    .imem_rdata     (imem_rdata),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_instr      (out_instr),
    .out_pc         (out_pc)
`ifdef FETCH_PERF_CNT_EN
    ,
    .fetch_cnt      (fetch_cnt),
    .stall_cnt      (stall_cnt),
    .flush_cnt      (flush_cnt)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [63:0] a);
    return 32'(a >> 2);
  endfunction

  // Instruction memory: one-cycle read latency.
  always @(posedge clk) if (imem_rd_en) imem_rdata <= mem_word(imem_addr);

  int checks = 0;
  int passes = 0;
  int hs_cnt = 0;
  int m_fetch = 0, m_stall = 0, m_flush = 0;
  fetch_entry_t exp_q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Decode must see target, target+4, ... in order after any reset or redirect.
  task automatic restart_stream(input logic [63:0] tgt);
    exp_q.delete();
    for (int i = 0; i < 16; i++) begin
      logic [63:0] p;
      p = tgt + 64'(4 * i);
      exp_q.push_back('{instr: mem_word(p), pc: p});
    end
  endtask

  always @(negedge clk) begin
    fetch_entry_t e;
    logic [63:0]  p;
    if (reset) begin
      m_fetch = 0; m_stall = 0; m_flush = 0;
    end else begin
      if (imem_rd_en) m_fetch++;
      if (redirect_valid) m_flush++;
      if (!redirect_valid && !imem_rd_en) m_stall++;
      if (out_valid && out_ready && !redirect_valid) begin
        while (exp_q.size() > 0 && exp_q.size() < 4) begin
          p = exp_q[$].pc + 64'd4;
          exp_q.push_back('{instr: mem_word(p), pc: p});
        end
        if (exp_q.size() == 0) begin
          checks++;
          $display("FAIL stream_empty: got handshake pc %h expected none", out_pc);
        end else begin
          e = exp_q.pop_front();
          chk("stream_pc", out_pc, e.pc);
          chk("stream_instr", 64'(out_instr), 64'(e.instr));
        end
        hs_cnt++;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    redirect_valid = 1'b0;
    tick(2);
    chk("rst_rd_en", 64'(imem_rd_en), 64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_pc", out_pc, 64'd0);
    chk("rst_out_instr", 64'(out_instr), 64'd0);
    chk("rst_addr", imem_addr, RST_PC);
    restart_stream(RST_PC);
    reset = 1'b0;
  endtask

  task automatic redirect_to(input logic [63:0] tgt);
    redirect_valid = 1'b1;
    redirect_pc = tgt;
    restart_stream(tgt);
  endtask

  initial begin
    int t_rd, t_vld, vcnt, rd_cnt, hs0;
    logic found;

    // Reset release, latency and sustained throughput.
    out_ready = 1'b1;
    do_reset();
    t_rd = -1; t_vld = -1; vcnt = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (imem_rd_en && t_rd < 0) t_rd = i;
      if (out_valid && t_vld < 0) t_vld = i;
      if (out_valid) vcnt++;
    end
    chk("first_rd_cycle", 64'(t_rd), 64'd0);
    chk("first_latency", 64'(t_vld - t_rd), 64'd2);
    chk("throughput", 64'(vcnt), 64'(10 - t_vld));

    // Decode stalled: credits cap the reads at DEPTH, PC holds.
    tick(1);
    out_ready = 1'b0;
    do_reset();
    rd_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (imem_rd_en) rd_cnt++;
    end
    chk("stall_reads", 64'(rd_cnt), 64'(DEPTH));
    chk("stall_rd_en", 64'(imem_rd_en), 64'd0);
    chk("stall_pc", imem_addr, 64'h1010);
    chk("stall_valid", 64'(out_valid), 64'd1);
    tick(1);
    hs0 = hs_cnt;
    out_ready = 1'b1;
    tick(8);
    chk("drain_progress", 64'(hs_cnt - hs0 >= 4), 64'd1);

    // Redirect with 3 queued entries and a read in flight.
    out_ready = 1'b0;
    do_reset();
    tick(4);
    chk("pre_redirect_valid", 64'(out_valid), 64'd1);
    out_ready = 1'b1;
    redirect_to(64'h2000);
    #1;
    chk("redirect_no_issue", 64'(imem_rd_en), 64'd0);
    tick(1);
    redirect_valid = 1'b0;
    #1;
    chk("post_flush_valid", 64'(out_valid), 64'd0);
    chk("post_flush_addr", imem_addr, 64'h2000);
    chk("post_flush_rd_en", 64'(imem_rd_en), 64'd1);
    tick(8);

    // Back-to-back redirects: the second target wins.
    redirect_to(64'h3000);
    tick(1);
    redirect_to(64'h4000);
    tick(1);
    redirect_valid = 1'b0;
    #1;
    chk("b2b_addr", imem_addr, 64'h4000);
    tick(8);

    // PC wrap at the top of the address space.
    redirect_to(64'hFFFF_FFFF_FFFF_FFF8);
    tick(1);
    redirect_valid = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      @(negedge clk);
      if (imem_rd_en && imem_addr == 64'hFFFF_FFFF_FFFF_FFFC) found = 1'b1;
    end
    chk("wrap_seen", 64'(found), 64'd1);
    @(negedge clk);
    chk("wrap_addr", imem_addr, 64'd0);
    tick(8);

    // Randomised traffic: ready jitter, redirects, occasional mid-run reset.
    hs0 = hs_cnt;
    for (int i = 0; i < 1500; i++) begin
      int r;
      out_ready = ($urandom_range(0, 99) < 70);
      r = $urandom_range(0, 199);
      if (r < 6) begin
        redirect_to({$urandom, $urandom} & ~64'd3);
      end else if (r == 6) begin
        redirect_valid = 1'b0;
        do_reset();
      end else begin
        redirect_valid = 1'b0;
      end
      tick(1);
    end
    redirect_valid = 1'b0;
    tick(4);
    chk("random_progress", 64'(hs_cnt - hs0 > 300), 64'd1);

`ifdef FETCH_PERF_CNT_EN
    chk("fetch_cnt", 64'(fetch_cnt), 64'(m_fetch));
    chk("stall_cnt", 64'(stall_cnt), 64'(m_stall));
    chk("flush_cnt", 64'(flush_cnt), 64'(m_flush));
`endif

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: got no completion expected finish");
    $fatal(1);
  end

endmodule
